// File: rtl/sd_rx_block_packer_pkg.sv
// ============================================================================
// Module      : sd_rx_block_packer_pkg
// Description : Shared FSM states, CRC-16 and packing constants for the SD
//               receive block packer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sd_rx_block_packer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle       = 3'd0;
    localparam state_t c_st_wait_start = 3'd1;
    localparam state_t c_st_data       = 3'd2;
    localparam state_t c_st_crc        = 3'd3;
    localparam state_t c_st_stop       = 3'd4;
    localparam state_t c_st_done       = 3'd5;

    localparam logic [15:0] c_crc16_poly   = 16'h1021;
    localparam int          c_nib_per_word = 8;
    localparam int          c_crc_len      = 16;

    // Bit offset of nibble idx inside a word: bytes little-endian, high nibble first.
    function automatic logic [4:0] nib_offset(input logic [2:0] idx);
        return {idx[2:1], ~idx[0], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd_crc16_lane.sv
// ============================================================================
// Module      : sd_crc16_lane
// Description : Serial one-bit-per-cycle CRC-16-CCITT (init 0) for one SD
//               DAT lane, MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sd_crc16_lane
    import sd_rx_block_packer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb  = r_crc[15] ^ i_bit;
    assign o_crc = r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= 16'h0000;
        end else if (i_clr) begin
            r_crc <= 16'h0000;
        end else if (i_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? c_crc16_poly : 16'h0000);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sd_rx_block_packer.sv
// ============================================================================
// Module      : sd_rx_block_packer
// Description : Receives one SD 4-bit data block (start bit, data, CRC, end
//               bit) and packs nibbles into 32-bit buffer words.
//               Optional macro SD_RX_CRC16_EN enables per-lane CRC-16 checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sd_rx_block_packer
    import sd_rx_block_packer_pkg::*;
#(
    parameter int DATA    = 32,
    parameter int ADDR    = 7,
    parameter int TIMEOUT = 65535
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dat_valid,
    input  logic [3:0]      dat_in,
    output logic            bram_wr,
    output logic [ADDR-1:0] bram_addr,
    output logic [DATA-1:0] bram_din,
    output logic            busy,
    output logic            done,
    output logic            crc_err,
    output logic            timeout_err
);

    localparam int                c_nib_w   = ADDR + 3;
    localparam int                c_crc_w   = $clog2(c_crc_len);
    localparam int                c_to_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_nib_w-1:0] c_nib_last = {c_nib_w{1'b1}};
    localparam logic [c_crc_w-1:0] c_crc_last = c_crc_w'(c_crc_len - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT - 1);
    localparam logic [2:0]         c_nib_lastw = 3'(c_nib_per_word - 1);

    state_t             r_state;
    logic [c_nib_w-1:0] r_nib_cnt;
    logic [c_crc_w-1:0] r_crc_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [DATA-1:0]    r_word;
    logic               r_bram_wr;
    logic [ADDR-1:0]    r_bram_addr;
    logic [DATA-1:0]    r_bram_din;
    logic               r_crc_err;
    logic               r_timeout_err;

    logic [DATA-1:0]    w_word_next;
    logic               w_start_ok;
    logic               w_crc_bad;

    assign w_start_ok = start && !abort && (r_state == c_st_idle);

    always_comb begin
        w_word_next = r_word;
        w_word_next[nib_offset(r_nib_cnt[2:0]) +: 4] = dat_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_nib_cnt     <= '0;
            r_crc_cnt     <= '0;
            r_to_cnt      <= '0;
            r_word        <= '0;
            r_bram_wr     <= 1'b0;
            r_bram_addr   <= '0;
            r_bram_din    <= '0;
            r_crc_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_bram_wr <= 1'b0;
            if (abort) begin
                // Abort wins over everything; error flags are deliberately kept.
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_start_ok) begin
                            r_state       <= c_st_wait_start;
                            r_nib_cnt     <= '0;
                            r_crc_cnt     <= '0;
                            r_to_cnt      <= '0;
                            r_bram_addr   <= '0;
                            r_crc_err     <= 1'b0;
                            r_timeout_err <= 1'b0;
                        end
                    end
                    c_st_wait_start: begin
                        if (dat_valid) begin
                            if (dat_in == 4'h0) begin
                                r_state <= c_st_data;
                            end else if (r_to_cnt == c_to_last) begin
                                r_timeout_err <= 1'b1;
                                r_state       <= c_st_idle;
                            end else begin
                                r_to_cnt <= r_to_cnt + c_to_w'(1);
                            end
                        end
                    end
                    c_st_data: begin
                        if (dat_valid) begin
                            r_word    <= w_word_next;
                            r_nib_cnt <= r_nib_cnt + c_nib_w'(1);
                            if (r_nib_cnt[2:0] == c_nib_lastw) begin
                                r_bram_wr   <= 1'b1;
                                r_bram_addr <= r_nib_cnt[c_nib_w-1:3];
                                r_bram_din  <= w_word_next;
                            end
                            if (r_nib_cnt == c_nib_last) begin
                                r_state <= c_st_crc;
                            end
                        end
                    end
                    c_st_crc: begin
                        if (dat_valid) begin
                            r_crc_cnt <= r_crc_cnt + c_crc_w'(1);
                            if (r_crc_cnt == c_crc_last) begin
                                r_state <= c_st_stop;
                            end
                        end
                    end
                    c_st_stop: begin
                        if (dat_valid) begin
                            if ((dat_in != 4'hF) || w_crc_bad) begin
                                r_crc_err <= 1'b1;
                            end
                            r_state <= c_st_done;
                        end
                    end
                    c_st_done: begin
                        r_state <= c_st_idle;
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

`ifdef SD_RX_CRC16_EN
    logic [3:0][15:0] w_crc;
    logic [3:0][15:0] r_rx_crc;
    logic             w_crc_en;

    assign w_crc_en = dat_valid && !abort && (r_state == c_st_data);

    generate
        for (genvar g = 0; g < 4; g++) begin : g_crc_lane
            sd_crc16_lane u_crc_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .i_en  (w_crc_en),
                .i_clr (w_start_ok),
                .i_bit (dat_in[g]),
                .o_crc (w_crc[g])
            );
        end
    endgenerate

    // Received CRC bits arrive MSB first on each lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_crc <= '0;
        end else if (w_start_ok) begin
            r_rx_crc <= '0;
        end else if (dat_valid && !abort && (r_state == c_st_crc)) begin
            for (int i = 0; i < 4; i++) begin
                r_rx_crc[i] <= {r_rx_crc[i][14:0], dat_in[i]};
            end
        end
    end

    assign w_crc_bad = (w_crc != r_rx_crc);
`else
    assign w_crc_bad = 1'b0;
`endif

    assign bram_wr     = r_bram_wr;
    assign bram_addr   = r_bram_addr;
    assign bram_din    = r_bram_din;
    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign crc_err     = r_crc_err;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_sd_rx_block_packer.sv
// ============================================================================
// Module      : tb_sd_rx_block_packer
// Description : Randomized self-checking bench for sd_rx_block_packer with a
//               stream-level model (CRC by polynomial division).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sd_rx_block_packer;

    localparam int DATA    = 32;
    localparam int ADDR    = 7;
    localparam int TIMEOUT = 40;
    localparam int WORDS   = 1 << ADDR;
    localparam int DNIBS   = 8 * WORDS;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            dat_valid = 1'b0;
    logic [3:0]      dat_in = 4'h0;
    logic            bram_wr;
    logic [ADDR-1:0] bram_addr;
    logic [DATA-1:0] bram_din;
    logic            busy;
    logic            done;
    logic            crc_err;
    logic            timeout_err;

    sd_rx_block_packer #(
        .DATA    (DATA),
        .ADDR    (ADDR),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .dat_valid   (dat_valid),
        .dat_in      (dat_in),
        .bram_wr     (bram_wr),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .busy        (busy),
        .done        (done),
        .crc_err     (crc_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass = 0;
    int wr_count = 0;
    int done_count = 0;

    logic [ADDR-1:0] exp_addr_q[$];
    logic [DATA-1:0] exp_data_q[$];
    logic [DATA-1:0] dut_mem [WORDS];
    logic [7:0]      blk_bytes [WORDS*4];
    logic [3:0]      stream[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // CRC as remainder of M(x)*x^16 divided by G(x), via long division.
    function automatic logic [15:0] crc_div(input bit msg[$]);
        bit          r[$];
        logic [16:0] gen;
        logic [15:0] crc;
        gen = 17'h11021;
        r = msg;
        for (int i = 0; i < 16; i++) r.push_back(1'b0);
        for (int i = 0; i + 16 < r.size(); i++) begin
            if (r[i]) begin
                for (int j = 0; j < 17; j++) r[i+j] = r[i+j] ^ gen[16-j];
            end
        end
        for (int j = 0; j < 16; j++) crc[15-j] = r[r.size()-16+j];
        return crc;
    endfunction

    function automatic logic [DATA-1:0] model_word(input int w);
        return {blk_bytes[4*w+3], blk_bytes[4*w+2], blk_bytes[4*w+1], blk_bytes[4*w]};
    endfunction

    task automatic build_stream(input int mode, input bit flip, input logic [3:0] endv);
        bit          q[$];
        logic [15:0] lane_crc [4];
        logic [3:0]  nb;
        stream.delete();
        stream.push_back(4'h0);
        for (int k = 0; k < WORDS*4; k++) begin
            blk_bytes[k] = (mode == 0) ? 8'(k) : 8'($urandom);
            stream.push_back(blk_bytes[k][7:4]);
            stream.push_back(blk_bytes[k][3:0]);
        end
        for (int ln = 0; ln < 4; ln++) begin
            q.delete();
            for (int k = 1; k <= DNIBS; k++) q.push_back(stream[k][ln]);
            lane_crc[ln] = crc_div(q);
        end
        for (int j = 0; j < 16; j++) begin
            nb = {lane_crc[3][15-j], lane_crc[2][15-j], lane_crc[1][15-j], lane_crc[0][15-j]};
            if (flip && j == 10) nb[0] = ~nb[0];
            stream.push_back(nb);
        end
        stream.push_back(endv);
    endtask

    task automatic nib(input logic [3:0] v, input int pct, input bit inj);
        while (int'($urandom_range(99)) >= pct) begin
            dat_valid = 1'b0;
            dat_in    = 4'($urandom);
            start     = inj && ($urandom_range(7) == 0);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        dat_valid = 1'b1;
        dat_in    = v;
        @(posedge clk); #1;
        dat_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_block(input int mode, input int pct, input bit flip,
                             input logic [3:0] endv, input int n_send, input bit inj);
        int dn;
        build_stream(mode, flip, endv);
        dn = n_send - 1;
        if (dn < 0) dn = 0;
        if (dn > DNIBS) dn = DNIBS;
        for (int w = 0; w < dn / 8; w++) begin
            exp_addr_q.push_back(ADDR'(w));
            exp_data_q.push_back(model_word(w));
        end
        pulse_start();
        for (int i = 0; i < n_send && i < stream.size(); i++) nib(stream[i], pct, inj);
    endtask

    task automatic check_zero_outputs(string tag);
        check({tag, "_bram_wr"},     64'(bram_wr),     64'd0);
        check({tag, "_bram_addr"},   64'(bram_addr),   64'd0);
        check({tag, "_bram_din"},    64'(bram_din),    64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_done"},        64'(done),        64'd0);
        check({tag, "_crc_err"},     64'(crc_err),     64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    // Compare process: every write pulse must match the next modelled write.
    always @(negedge clk) begin
        if (rst_n && bram_wr) begin
            wr_count++;
            check("wr_expected", 64'(exp_addr_q.size() > 0), 64'd1);
            if (exp_addr_q.size() > 0) begin
                check("wr_addr", 64'(bram_addr), 64'(exp_addr_q.pop_front()));
                check("wr_data", 64'(bram_din),  64'(exp_data_q.pop_front()));
            end
            dut_mem[bram_addr] = bram_din;
        end
        if (rst_n && done) done_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ascii[$];
        logic [7:0] ch;
        int         wr0, dn0;
        logic       exp_flip_err;

        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Pin the model itself to known values.
        for (int c = 0; c < 9; c++) begin
            ch = 8'h31 + 8'(c);
            for (int b = 7; b >= 0; b--) ascii.push_back(ch[b]);
        end
        check("model_crc_123456789", 64'(crc_div(ascii)), 64'h31C3);
        build_stream(0, 1'b0, 4'hF);
        check("model_word0",   64'(model_word(0)),   64'h03020100);
        check("model_word127", 64'(model_word(127)), 64'hFFFEFDFC);

        // Nominal block, always valid.
        wr0 = wr_count; dn0 = done_count;
        run_block(0, 100, 1'b0, 4'hF, DNIBS + 18, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("nom_wr_count", 64'(wr_count - wr0), 64'd128);
        check("nom_done",     64'(done_count - dn0), 64'd1);
        check("nom_crc_err",  64'(crc_err), 64'd0);
        check("nom_busy",     64'(busy), 64'd0);
        check("nom_pending",  64'(exp_addr_q.size()), 64'd0);
        check("nom_mem0",     64'(dut_mem[0]), 64'h03020100);
        check("nom_mem127",   64'(dut_mem[127]), 64'hFFFEFDFC);

        // Lane 0 CRC bit 5 flipped.
`ifdef SD_RX_CRC16_EN
        exp_flip_err = 1'b1;
`else
        exp_flip_err = 1'b0;
`endif
        wr0 = wr_count; dn0 = done_count;
        run_block(0, 100, 1'b1, 4'hF, DNIBS + 18, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("flip_wr_count", 64'(wr_count - wr0), 64'd128);
        check("flip_done",     64'(done_count - dn0), 64'd1);
        check("flip_crc_err",  64'(crc_err), 64'(exp_flip_err));

        // Random data, sparse valid, stray starts, bad end bit.
        wr0 = wr_count; dn0 = done_count;
        run_block(1, 30, 1'b0, 4'h7, DNIBS + 18, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("endbit_wr_count", 64'(wr_count - wr0), 64'd128);
        check("endbit_done",     64'(done_count - dn0), 64'd1);
        check("endbit_crc_err",  64'(crc_err), 64'd1);
        check("endbit_pending",  64'(exp_addr_q.size()), 64'd0);

        // Start-bit timeout.
        wr0 = wr_count; dn0 = done_count;
        pulse_start();
        check("to_crc_err_cleared", 64'(crc_err), 64'd0);
        for (int i = 0; i < TIMEOUT - 1; i++) nib(4'hF, 50, 1'b0);
        check("to_busy_before",  64'(busy), 64'd1);
        check("to_err_before",   64'(timeout_err), 64'd0);
        nib(4'hF, 50, 1'b0);
        check("to_busy_after",   64'(busy), 64'd0);
        check("to_err_after",    64'(timeout_err), 64'd1);
        check("to_no_wr",        64'(wr_count - wr0), 64'd0);
        check("to_no_done",      64'(done_count - dn0), 64'd0);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("to_err_retained", 64'(timeout_err), 64'd1);

        // Abort after 300 data nibbles.
        wr0 = wr_count; dn0 = done_count;
        run_block(0, 100, 1'b0, 4'hF, 301, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_busy",     64'(busy), 64'd0);
        check("abort_wr_count", 64'(wr_count - wr0), 64'd37);
        for (int i = 0; i < 20; i++) nib(4'($urandom), 100, 1'b0);
        check("abort_no_more_wr", 64'(wr_count - wr0), 64'd37);
        check("abort_no_done",    64'(done_count - dn0), 64'd0);

        // Next block after abort starts at address 0, sparse valid.
        wr0 = wr_count; dn0 = done_count;
        run_block(0, 30, 1'b0, 4'hF, DNIBS + 18, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("sparse_wr_count", 64'(wr_count - wr0), 64'd128);
        check("sparse_done",     64'(done_count - dn0), 64'd1);
        check("sparse_crc_err",  64'(crc_err), 64'd0);
        check("sparse_mem0",     64'(dut_mem[0]), 64'h03020100);
        check("sparse_mem77",    64'(dut_mem[77]), 64'h37363534);

        // Reset in the middle of DATA.
        dn0 = done_count;
        run_block(1, 100, 1'b0, 4'hF, 101, 1'b0);
        #2;
        exp_addr_q.delete();
        exp_data_q.delete();
        rst_n = 1'b0;
        #1 check_zero_outputs("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        wr0 = wr_count;
        for (int i = 0; i < 10; i++) begin
            nib(4'h0, 100, 1'b0);
            check("midrst_idle_busy", 64'(busy), 64'd0);
        end
        check("midrst_no_wr",   64'(wr_count - wr0), 64'd0);
        check("midrst_no_done", 64'(done_count - dn0), 64'd0);

        // Start and abort together resolve to abort.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);

        // Recovery block with random data.
        wr0 = wr_count; dn0 = done_count;
        run_block(1, 100, 1'b0, 4'hF, DNIBS + 18, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rec_wr_count", 64'(wr_count - wr0), 64'd128);
        check("rec_done",     64'(done_count - dn0), 64'd1);
        check("rec_crc_err",  64'(crc_err), 64'd0);
        check("rec_pending",  64'(exp_addr_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
